// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Memory-to-writeback stage. Holds one retiring instruction. For loads it waits
// for the synchronous data-memory response, then aligns and extends the data.
// It emits one registered register-file write per retired instruction.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_i / ready_o   upstream handshake; accept = valid_i && ready_o && !flush_i
//   flush_i             discards the held instruction (and any incoming one)
//   rd_addr_i, rd_wr_en_i, wb_sel_i, load_funct3_i,
//   alu_result_i, pc_plus4_i, imm_i      instruction fields captured on accept
//   dmem_rdata_i, dmem_rvalid_i          data-memory read response
//   rd_addr_o, rd_data_o, rd_wr_en_o     register-file write port (registered)
//   retire_o, load_err_o                 one-cycle completion / illegal-load pulses
module mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_wr_en_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [2:0]            load_funct3_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [XLEN-1:0]       pc_plus4_i,
    input  logic [XLEN-1:0]       imm_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    input  logic                  dmem_rvalid_i,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  rd_wr_en_o,
    output logic                  retire_o,
    output logic                  load_err_o
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HOLD      = 2'd1,
        WAIT_LOAD = 2'd2,
        DROP      = 2'd3
    } state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t state_q, state_d;

    // Capture register
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic                  rd_wr_en_q;
    logic [1:0]            wb_sel_q;
    logic [2:0]            funct3_q;
    logic [XLEN-1:0]       alu_q, pc4_q, imm_q;

    // Output register
    logic [REG_ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [XLEN-1:0]       out_data_q, out_data_d;
    logic                  out_we_q, out_we_d;
    logic                  out_ret_q, out_ret_d;
    logic                  out_err_q, out_err_d;

    logic accept, complete, in_is_load, load_legal;
    logic [XLEN-1:0] load_val, wb_val;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [7:0]  byte_lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = dmem_rdata_i[8*gi +: 8];
        end
    endgenerate

    assign in_is_load = (wb_sel_i == SEL_LOAD);
    assign ready_o    = (state_q == EMPTY) || (state_q == HOLD) ||
                        ((state_q == WAIT_LOAD) && dmem_rvalid_i);
    assign accept     = valid_i && ready_o && !flush_i;
    // A flush on the completion edge wins: the held instruction never retires.
    assign complete   = !flush_i && ((state_q == HOLD) ||
                        ((state_q == WAIT_LOAD) && dmem_rvalid_i));

    // Load alignment: byte lane by offset, halfword by offset[1].
    assign sel_byte = byte_lane[alu_q[1:0]];
    assign sel_half = alu_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        load_legal = 1'b1;
        load_val   = '0;
        case (funct3_q)
            3'b000:  load_val = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, sel_byte};
            3'b001:  load_val = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, sel_half};
            3'b010:  load_val = dmem_rdata_i;
            default: load_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            SEL_ALU:  wb_val = alu_q;
            SEL_LOAD: wb_val = load_val;
            SEL_PC4:  wb_val = pc4_q;
            default:  wb_val = imm_q;
        endcase
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = in_is_load ? WAIT_LOAD : HOLD;
            end
            HOLD: begin
                if (accept) state_d = in_is_load ? WAIT_LOAD : HOLD;
                else        state_d = EMPTY;
            end
            WAIT_LOAD: begin
                if (flush_i)            state_d = dmem_rvalid_i ? EMPTY : DROP;
                else if (dmem_rvalid_i) state_d = accept ? (in_is_load ? WAIT_LOAD : HOLD) : EMPTY;
            end
            DROP: begin
                if (dmem_rvalid_i) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output register next values; address/data hold when nothing completes.
    always_comb begin
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_we_d   = 1'b0;
        out_ret_d  = 1'b0;
        out_err_d  = 1'b0;
        if (complete) begin
            out_addr_d = rd_addr_q;
            out_ret_d  = 1'b1;
            if ((wb_sel_q == SEL_LOAD) && !load_legal) begin
                out_data_d = '0;
                out_err_d  = 1'b1;
            end else begin
                out_data_d = wb_val;
                out_we_d   = rd_wr_en_q && (rd_addr_q != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            rd_addr_q  <= '0;
            rd_wr_en_q <= 1'b0;
            wb_sel_q   <= '0;
            funct3_q   <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_we_q   <= 1'b0;
            out_ret_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_we_q   <= out_we_d;
            out_ret_q  <= out_ret_d;
            out_err_q  <= out_err_d;
            if (accept) begin
                rd_addr_q  <= rd_addr_i;
                rd_wr_en_q <= rd_wr_en_i;
                wb_sel_q   <= wb_sel_i;
                funct3_q   <= load_funct3_i;
                alu_q      <= alu_result_i;
                pc4_q      <= pc_plus4_i;
                imm_q      <= imm_i;
            end
        end
    end

    assign rd_addr_o  = out_addr_q;
    assign rd_data_o  = out_data_q;
    assign rd_wr_en_o = out_we_q;
    assign retire_o   = out_ret_q;
    assign load_err_o = out_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed test-plan cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, flush_i, rd_wr_en_i, dmem_rvalid_i;
    logic        ready_o, rd_wr_en_o, retire_o, load_err_o;
    logic [4:0]  rd_addr_i, rd_addr_o;
    logic [1:0]  wb_sel_i;
    logic [2:0]  load_funct3_i;
    logic [31:0] alu_result_i, pc_plus4_i, imm_i, dmem_rdata_i, rd_data_o;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .rd_addr_i(rd_addr_i), .rd_wr_en_i(rd_wr_en_i),
        .wb_sel_i(wb_sel_i), .load_funct3_i(load_funct3_i),
        .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i), .imm_i(imm_i),
        .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wr_en_o(rd_wr_en_o),
        .retire_o(retire_o), .load_err_o(load_err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu, pc4, imm;
    } instr_t;

    bit          m_held, m_drop;
    instr_t      m_ins;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_we, e_ret, e_err;

    function automatic bit legal_f3(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // Load result from plain shifts/masks and two's-complement arithmetic.
    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned off, b, h;
        off = addr % 4;
        b = (word >> (off * 8)) & 32'hFF;
        h = (word >> ((off / 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_ready();
        if (m_drop) return 1'b0;
        if (!m_held) return 1'b1;
        if (m_ins.sel != 2'b01) return 1'b1;
        return dmem_rvalid_i;
    endfunction

    task automatic model_reset();
        m_held = 0; m_drop = 0;
        e_addr = 0; e_data = 0; e_we = 0; e_ret = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit rdy, acc, done, is_ld;
        rdy   = model_ready();
        acc   = valid_i && rdy && !flush_i;
        is_ld = m_held && (m_ins.sel == 2'b01);
        done  = m_held && !flush_i && (!is_ld || dmem_rvalid_i);
        e_we = 0; e_ret = 0; e_err = 0;
        if (done) begin
            e_addr = m_ins.rd;
            e_ret  = 1;
            if (is_ld && !legal_f3(m_ins.f3)) begin
                e_data = 0;
                e_err  = 1;
            end else begin
                case (m_ins.sel)
                    2'b00: e_data = m_ins.alu;
                    2'b01: e_data = load_value(m_ins.f3, m_ins.alu, dmem_rdata_i);
                    2'b10: e_data = m_ins.pc4;
                    default: e_data = m_ins.imm;
                endcase
                e_we = m_ins.we && (m_ins.rd != 0);
            end
        end
        if (m_drop) m_drop = !dmem_rvalid_i;
        else if (is_ld && flush_i && !dmem_rvalid_i) m_drop = 1;
        if (m_held && (done || flush_i)) m_held = 0;
        if (acc) begin
            m_held = 1;
            m_ins.rd = rd_addr_i; m_ins.we = rd_wr_en_i; m_ins.sel = wb_sel_i;
            m_ins.f3 = load_funct3_i; m_ins.alu = alu_result_i;
            m_ins.pc4 = pc_plus4_i; m_ins.imm = imm_i;
        end
    endtask

    // One clock: check ready before the edge, advance model on the edge,
    // compare registered outputs on the following falling edge.
    task automatic tick();
        #1;
        chk("ready_o", {31'd0, ready_o}, {31'd0, model_ready()});
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("rd_addr_o",  {27'd0, rd_addr_o}, {27'd0, e_addr});
        chk("rd_data_o",  rd_data_o, e_data);
        chk("rd_wr_en_o", {31'd0, rd_wr_en_o}, {31'd0, e_we});
        chk("retire_o",   {31'd0, retire_o},   {31'd0, e_ret});
        chk("load_err_o", {31'd0, load_err_o}, {31'd0, e_err});
    endtask

    task automatic idle_inputs();
        valid_i = 0; flush_i = 0; dmem_rvalid_i = 0;
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] pc4, input logic [31:0] imm);
        valid_i = 1; rd_addr_i = rd; rd_wr_en_i = we; wb_sel_i = sel;
        load_funct3_i = f3; alu_result_i = alu; pc_plus4_i = pc4; imm_i = imm;
    endtask

    // Issue a load, hold rvalid low for 'delay' cycles, then return rdata.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] rdata, input int delay);
        set_instr(rd, 1, 2'b01, f3, alu, 0, 0);
        tick();
        idle_inputs();
        for (int i = 0; i < delay; i++) begin
            #1 chk("load_wait_ready", {31'd0, ready_o}, 32'd0);
            tick();
        end
        dmem_rvalid_i = 1; dmem_rdata_i = rdata;
        tick();
        dmem_rvalid_i = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        set_instr(0, 0, 0, 0, 0, 0, 0);
        valid_i = 0; dmem_rdata_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready",  {31'd0, ready_o}, 32'd1);
        chk("rst_data",   rd_data_o, 32'd0);
        chk("rst_addr",   {27'd0, rd_addr_o}, 32'd0);
        chk("rst_pulses", {29'd0, rd_wr_en_o, retire_o, load_err_o}, 32'd0);
        rst_n = 1;

        // Model pinned against hand-computed load extensions
        chk("model_lb",  load_value(3'd0, 32'h1002, 32'h0080_0000), 32'hFFFF_FF80);
        chk("model_lbu", load_value(3'd4, 32'h1002, 32'h0080_0000), 32'h0000_0080);
        chk("model_lh",  load_value(3'd1, 32'h0002, 32'h8001_0000), 32'hFFFF_8001);

        // ADDI x5
        set_instr(5, 1, 2'b00, 0, 32'h10, 0, 0);
        tick();
        idle_inputs();
        tick();
        chk("addi_addr", {27'd0, rd_addr_o}, 32'd5);
        chk("addi_data", rd_data_o, 32'h10);
        chk("addi_we",   {30'd0, rd_wr_en_o, retire_o}, 32'd3);
        tick();
        chk("addi_pulse_end", {30'd0, rd_wr_en_o, retire_o}, 32'd0);

        // Four back-to-back non-loads
        for (int i = 1; i <= 4; i++) begin
            set_instr(5'(i), 1, 2'b11, 0, 0, 0, 32'h100 + i);
            tick();
            if (i > 1) chk("b2b_addr", {27'd0, rd_addr_o}, i - 1);
        end
        idle_inputs();
        tick();
        chk("b2b_last", rd_data_o, 32'h104);

        // Loads
        do_load(7, 3'd0, 32'h1002, 32'h0080_0000, 3);
        chk("lb_data", rd_data_o, 32'hFFFF_FF80);
        do_load(7, 3'd4, 32'h1002, 32'h0080_0000, 3);
        chk("lbu_data", rd_data_o, 32'h0000_0080);
        do_load(8, 3'd1, 32'h0002, 32'h8001_0000, 0);
        chk("lh_data", rd_data_o, 32'hFFFF_8001);

        // Write to x0
        set_instr(0, 1, 2'b00, 0, 32'h55, 0, 0);
        tick();
        idle_inputs();
        tick();
        chk("x0_ret_we", {30'd0, retire_o, rd_wr_en_o}, 32'd2);

        // Illegal funct3
        do_load(9, 3'd3, 32'h0, 32'hDEAD_BEEF, 1);
        chk("illegal_flags", {29'd0, load_err_o, rd_wr_en_o, retire_o}, 32'd5);
        chk("illegal_data", rd_data_o, 32'd0);

        // Flush during WAIT_LOAD, response two cycles later, then JAL x1
        set_instr(10, 1, 2'b01, 3'd2, 0, 0, 0);
        tick();
        idle_inputs();
        flush_i = 1;
        tick();
        flush_i = 0;
        #1 chk("drop_ready0", {31'd0, ready_o}, 32'd0);
        tick();
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h1234_5678;
        #1 chk("drop_ready1", {31'd0, ready_o}, 32'd0);
        tick();
        chk("drop_no_retire", {30'd0, retire_o, rd_wr_en_o}, 32'd0);
        dmem_rvalid_i = 0;
        #1 chk("drop_ready_back", {31'd0, ready_o}, 32'd1);
        set_instr(1, 1, 2'b10, 0, 0, 32'h104, 0);
        tick();
        idle_inputs();
        tick();
        chk("jal_data", rd_data_o, 32'h104);

        // Asynchronous reset mid-load; a stray response afterwards is ignored
        set_instr(11, 1, 2'b01, 3'd2, 0, 0, 0);
        tick();
        idle_inputs();
        rst_n = 0;
        #1 model_reset();
        chk("async_rst_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1;
        dmem_rvalid_i = 1;
        tick();
        chk("stray_rvalid", {31'd0, retire_o}, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            valid_i       = ($urandom_range(0, 99) < 60);
            flush_i       = ($urandom_range(0, 99) < 8);
            rd_addr_i     = 5'($urandom_range(0, 7));
            rd_wr_en_i    = ($urandom_range(0, 3) != 0);
            wb_sel_i      = 2'($urandom_range(0, 3));
            load_funct3_i = 3'($urandom_range(0, 7));
            alu_result_i  = $urandom;
            pc_plus4_i    = $urandom;
            imm_i         = $urandom;
            dmem_rdata_i  = $urandom;
            if (m_drop || (m_held && m_ins.sel == 2'b01))
                dmem_rvalid_i = ($urandom_range(0, 99) < 40);
            else
                dmem_rvalid_i = ($urandom_range(0, 99) < 10);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
